// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-unit types, Booth opcodes and width helper
`timescale 1ns/1ps
package arith_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ADD   = 4'b0010,
        SHIFT = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_PM   = 3'd1,
        BOOTH_P2M  = 3'd2,
        BOOTH_M2M  = 3'd3,
        BOOTH_MM   = 3'd4
    } booth_op_t;

    // Never returns 0 so a one-iteration counter still gets a bit.
    function automatic int clog2_int(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic booth_op_t booth_decode(input logic [2:0] window);
        booth_op_t op;
        case (window)
            3'b001, 3'b010: op = BOOTH_PM;
            3'b011:         op = BOOTH_P2M;
            3'b100:         op = BOOTH_M2M;
            3'b101, 3'b110: op = BOOTH_MM;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// rtl/booth_r4_multiplier_if.sv - start/busy/done multiply request interface
`timescale 1ns/1ps
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, output x, output y,
                    input busy, input done, input product);
    modport slave  (input start, input x, input y,
                    output busy, output done, output product);
endinterface

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - radix-4 Booth operand select feeding the accumulator adder
`timescale 1ns/1ps
module booth_r4_recoder
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] operand,
    output logic             cin
);
    logic [WIDTH+1:0] m2;
    booth_op_t        op;

    assign m2 = {m[WIDTH:0], 1'b0};
    assign op = booth_decode(window);

    // Negative picks are one's complement; the +1 rides in on the adder carry.
    always_comb begin
        operand = '0;
        cin     = 1'b0;
        case (op)
            BOOTH_PM:  operand = m;
            BOOTH_P2M: operand = m2;
            BOOTH_M2M: begin
                operand = ~m2;
                cin     = 1'b1;
            end
            BOOTH_MM: begin
                operand = ~m;
                cin     = 1'b1;
            end
            default: begin
                operand = '0;
                cin     = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/booth_r4_multiplier.sv
// rtl/booth_r4_multiplier.sv - sequential signed radix-4 Booth multiplier core
`timescale 1ns/1ps
module booth_r4_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_b,
    booth_r4_multiplier_if.slave        bus
);
    localparam int ITER  = WIDTH / 2;
    localparam int CNT_W = clog2_int(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t               state;
    logic [WIDTH+1:0]     a;
    logic [WIDTH-1:0]     q;
    logic                 qm1;
    logic [WIDTH+1:0]     m;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH+1:0]     operand;
    logic                 cin;
    logic [WIDTH+1:0]     sum;
    logic [2*WIDTH+2:0]   sh;

    booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
        .window  ({q[1:0], qm1}),
        .m       (m),
        .operand (operand),
        .cin     (cin)
    );

    assign sum = a + operand + {{(WIDTH+1){1'b0}}, cin};
    // Two extra A bits keep +/-2M of the most negative operand exact.
    assign sh  = $signed({a, q, qm1}) >>> 2;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            qm1         <= 1'b0;
            m           <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a        <= '0;
                        q        <= bus.y;
                        qm1      <= 1'b0;
                        m        <= {{2{bus.x[WIDTH-1]}}, bus.x};
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    a     <= sum;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a   <= sh[2*WIDTH+2:WIDTH+1];
                    q   <= sh[WIDTH:1];
                    qm1 <= sh[0];
                    if (cnt == LAST) begin
                        bus.product <= sh[2*WIDTH:1];
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
